// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: operation classes,
// major opcodes and the immediate-format select codes used by the decoder.
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    OPC_R      = 4'd0,
    OPC_I      = 4'd1,
    OPC_LOAD   = 4'd2,
    OPC_S      = 4'd3,
    OPC_BRANCH = 4'd4,
    OPC_JAL    = 4'd5,
    OPC_JALR   = 4'd6,
    OPC_LUI    = 4'd7,
    OPC_AUIPC  = 4'd8
  } op_class_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/instr_fifo.sv
// Two-entry, 32-bit first-word-fall-through buffer between the encoder and
// the instruction-memory write port.
module instr_fifo
  import instr_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [31:0] wdata_i,
  input  logic        pop_i,
  output logic [31:0] rdata_o,
  output logic        full_o,
  output logic        empty_o
);

  logic [31:0] mem_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        do_push, do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes RV32I instructions from field inputs, buffers them, and writes them
// to consecutive word addresses of an instruction memory.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op_class,
  input  logic [2:0]  func3,
  input  logic        func7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  input  logic        base_load,
  input  logic [31:0] base_addr,
  output logic        imem_we,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        err,
  output logic [15:0] count
);

  logic [6:0]  opcode;
  logic [2:0]  imm_sel;
  logic [2:0]  f3_eff;
  logic        legal;
  logic [31:0] word;
  logic        accept, push, pop;
  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_head;
  logic [31:0] ptr_q, ptr_d;
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = &{1'b0, base_addr[1:0]};

  always_comb begin
    opcode  = OP_R;
    imm_sel = IMM_I;
    f3_eff  = func3;
    legal   = 1'b1;
    case (op_class)
      OPC_R:      opcode = OP_R;
      OPC_I:      opcode = OP_I;
      OPC_LOAD:   opcode = OP_LOAD;
      OPC_S:      begin opcode = OP_S;      imm_sel = IMM_S; end
      OPC_BRANCH: begin opcode = OP_BRANCH; imm_sel = IMM_B; end
      OPC_JAL:    begin opcode = OP_JAL;    imm_sel = IMM_J; end
      OPC_JALR:   begin opcode = OP_JALR;   f3_eff  = 3'b000; end
      OPC_LUI:    begin opcode = OP_LUI;    imm_sel = IMM_U; end
      OPC_AUIPC:  begin opcode = OP_AUIPC;  imm_sel = IMM_U; end
      default:    legal = 1'b0;
    endcase

    case (imm_sel)
      IMM_S:   word = {imm[11:5], rs2, rs1, f3_eff, imm[4:0], opcode};
      IMM_B:   word = {imm[12], imm[10:5], rs2, rs1, f3_eff, imm[4:1], imm[11], opcode};
      IMM_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      IMM_U:   word = {imm[31:12], rd, opcode};
      default: word = {imm[11:0], rs1, f3_eff, rd, opcode};
    endcase

    // Register ops and immediate shifts carry func7 in the top bits instead of imm.
    if (op_class == OPC_R)
      word = {1'b0, func7, 5'b0, rs2, rs1, f3_eff, rd, opcode};
    else if (op_class == OPC_I && func3[1:0] == 2'b01)
      word[31:20] = {1'b0, func7, 5'b0, imm[4:0]};
  end

  assign in_ready = ~fifo_full & ~rst;
  assign accept   = in_valid & in_ready;
  assign push     = accept & legal;
  assign pop      = imem_we & imem_ready;

  instr_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (word),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign imem_we    = ~fifo_empty;
  assign imem_wdata = fifo_empty ? 32'h0 : fifo_head;
  assign imem_addr  = ptr_q;
  assign err        = err_q;
  assign count      = count_q;

  // A base load in the same cycle as a completed write overrides the increment.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q | (accept & ~legal);
    if (pop) begin
      ptr_d = ptr_q + 32'd4;
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end
    if (base_load) ptr_d = {base_addr[31:2], 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= 32'h0;
      count_q <= 16'h0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have these ports (clock and reset first): clk  in  1  sole clock, rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 in_valid  in  1  encode request valid. in_ready  out  1  request accepted when in_valid&in_ready.
REQ-004 op_class  in  4  0=R,1=I,2=LOAD,3=S,4=BRANCH,5=JAL,6=JALR,7=LUI,8=AUIPC; 9-15 illegal.
REQ-005 func3  in  3  funct3 field. func7  in  1  instruction bit 30 (SUB/SRA/SRAI).
REQ-006 rd, rs1, rs2  in  5 each  register indices.
REQ-007 imm  in  32  full immediate value; the format slices it.
REQ-008 base_load  in  1  load write pointer. base_addr  in  32  new byte address (bits 1:0 ignored, forced 0).
REQ-009 imem_we  out  1  instruction-memory write strobe. imem_ready  in  1  memory accepts write when imem_we&imem_ready.
REQ-010 imem_addr  out  32  byte address of write. imem_wdata  out  32  encoded instruction word.
REQ-011 err  out  1  sticky illegal-op_class flag. count  out  16  instructions written since reset, saturating at 0xFFFF.

Function
REQ-012 Opcodes SHALL be: R 0110011, I 0010011, LOAD 0000011, S 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-013 R: {1'b0,func7,5'b0,rs2,rs1,func3,rd,op}.
REQ-014 I: {imm[11:0],rs1,func3,rd,op}. Exception: when func3=001 or 101, bits 31:25 = {1'b0,func7,5'b0} and bits 24:20 = imm[4:0].
REQ-015 LOAD and JALR: I layout; JALR forces func3=000.
REQ-016 S: {imm[11:5],rs2,rs1,func3,imm[4:0],op}.
REQ-017 BRANCH: {imm[12],imm[10:5],rs2,rs1,func3,imm[4:1],imm[11],op}; imm[0] ignored.
REQ-018 JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}. LUI/AUIPC: {imm[31:12],rd,op}.
REQ-019 Unused fields for a class SHALL be ignored.
REQ-020 An accepted legal request SHALL be encoded and pushed into a 2-entry FIFO on the same clock edge.
REQ-021 in_ready = FIFO not full; it SHALL NOT depend on a same-cycle pop.
REQ-022 An accepted illegal op_class SHALL set err on that edge and SHALL NOT be pushed.
REQ-023 imem_we = FIFO not empty; imem_wdata = FIFO head; imem_addr = write pointer. All are registered-state driven, with no combinational path from in_* to imem_*.
REQ-024 Minimum latency from request acceptance to imem_we SHALL be 1 cycle.
REQ-025 On imem_we&imem_ready: pop the head, advance the pointer by 4, and increment count (saturating). The pointer wraps from 0xFFFF_FFFC to 0x0000_0000.
REQ-026 A simultaneous push and pop SHALL leave occupancy unchanged and keep order.
REQ-027 Push to a full FIFO is impossible because in_ready=0.
REQ-028 While imem_ready=0, imem_addr and imem_wdata SHALL hold stable.
REQ-029 base_load SHALL set the pointer to {base_addr[31:2],2'b00} on the edge.
REQ-030 If base_load coincides with a completed write, that write uses the old address and base_load wins the next pointer value.
REQ-031 FIFO contents are unaffected by base_load.

Reset
REQ-032 When rst is asserted, regardless of clk: FIFO empty; imem_we=0; imem_addr=0; imem_wdata=0; in_ready=0 while rst is high, then 1; err=0; count=0. FIFO storage contents are don't-care.
REQ-033 Reset asserted mid-transfer SHALL discard all queued instructions. No write completes in the cycle rst is high.

Structure
REQ-034 A shared package SHALL hold: the op_class enumeration, the 7-bit opcode constants, and the imm_sel format codes (I=000, S=001, B=010, J=011, U=100) shared with the control decoder.
REQ-035 One sub-module, instr_fifo (2-entry, 32-bit, with push/pop/full/empty), SHALL hold the buffering. Encoding stays combinational in instr_encoder ahead of the push.

Verification
REQ-036 Reset, then base_load base_addr=0x100, then I rd=1 rs1=0 f3=0 imm=5 with imem_ready=1 -> next cycle: imem_we=1, addr 0x100, wdata 0x00500093; count then becomes 1.
REQ-037 Back-to-back R add rd3 rs1=1 rs2=2, then R f7=1 same regs -> wdata 0x002081B3 at 0x100, then 0x402081B3 at 0x104.
REQ-038 S f3=010 rs1=1 rs2=2 imm=8; BRANCH f3=0 rs1=1 rs2=2 imm=8; JAL rd=1 imm=16; LUI rd=5 imm=0x12345000 -> 0x0020A423, 0x00208463, 0x010000EF, 0x123452B7 in order.
REQ-039 imem_ready=0 with 3 requests offered -> two accepted, then in_ready=0, imem outputs stable. Raise imem_ready -> three writes in order, contiguous addresses.
REQ-040 op_class=12 accepted -> err=1 (sticky), no imem_we, count unchanged. Base 0xFFFF_FFFC plus two writes -> second write at 0x0000_0000.
REQ-041 rst pulsed while 2 entries are queued -> imem_we=0 immediately, addr=0, count=0, and nothing written after release.
